// File: rtl/dmem_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// dmem_arbiter : time-shares the data-memory port between CPU and host
// Revision 1.0
// ------------------------------------------------------------------
module dmem_arbiter #(
  parameter int AW          = 8,
  parameter int DW          = 16,
  parameter int CPU_QUANTUM = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run_en,
  output logic          cpu_enable,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_we,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    ST_CPU    = 3'd0,
    ST_FREEZE = 3'd1,
    ST_GRANT  = 3'd2,
    ST_RDATA  = 3'd3,
    ST_ACK    = 3'd4
  } state_t;

  localparam logic [7:0] c_quantum = 8'(CPU_QUANTUM);

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    cnt_dec;
  logic          cpu_enable_q, cpu_enable_d;
  logic [DW-1:0] host_rdata_q, host_rdata_d;
  logic          lat_we_q, lat_we_d;
  logic [AW-1:0] lat_addr_q, lat_addr_d;
  logic [DW-1:0] lat_wdata_q, lat_wdata_d;

  // Leaving on the cycle whose decrement reaches zero gives exactly
  // CPU_QUANTUM CPU cycles, and never fewer than one.
  assign cnt_dec = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;

  assign cpu_enable = cpu_enable_q;
  assign cpu_rdata  = mem_rdata;
  assign host_rdata = host_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_CPU;
      cnt_q        <= 8'd0;
      cpu_enable_q <= 1'b0;
      host_rdata_q <= '0;
      lat_we_q     <= 1'b0;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cpu_enable_q <= cpu_enable_d;
      host_rdata_q <= host_rdata_d;
      lat_we_q     <= lat_we_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    host_rdata_d = host_rdata_q;
    lat_we_d     = lat_we_q;
    lat_addr_d   = lat_addr_q;
    lat_wdata_d  = lat_wdata_q;
    host_gnt     = 1'b0;
    host_ack     = 1'b0;
    mem_addr     = cpu_addr;
    mem_we       = 1'b0;
    mem_wdata    = cpu_wdata;

    case (state_q)
      ST_CPU: begin
        mem_we = cpu_we;
        cnt_d  = cnt_dec;
        if (host_req && (cnt_dec == 8'd0)) state_d = ST_FREEZE;
      end
      ST_FREEZE: begin
        lat_we_d    = host_we;
        lat_addr_d  = host_addr;
        lat_wdata_d = host_wdata;
        state_d     = host_req ? ST_GRANT : ST_CPU;
      end
      ST_GRANT: begin
        host_gnt  = 1'b1;
        mem_addr  = lat_addr_q;
        mem_we    = lat_we_q;
        mem_wdata = lat_wdata_q;
        state_d   = lat_we_q ? ST_ACK : ST_RDATA;
      end
      ST_RDATA: begin
        mem_addr     = lat_addr_q;
        mem_wdata    = lat_wdata_q;
        host_rdata_d = mem_rdata;
        state_d      = ST_ACK;
      end
      ST_ACK: begin
        host_ack  = 1'b1;
        mem_addr  = lat_addr_q;
        mem_wdata = lat_wdata_q;
        cnt_d     = c_quantum;
        state_d   = ST_CPU;
      end
      default: state_d = ST_CPU;
    endcase

    cpu_enable_d = (state_d == ST_CPU) ? run_en : 1'b0;

    // The state register may hold anything until the reset edge lands.
    if (rst) begin
      mem_we   = 1'b0;
      mem_addr = cpu_addr;
      host_gnt = 1'b0;
      host_ack = 1'b0;
    end
  end

endmodule
`default_nettype wire
